// File: rtl/axi_lite_timer_mc.sv
// Multi-channel AXI4-Lite timer: NUM_CH_p down-counters sharing one prescaler.
// Each channel has load/auto-reload/one-shot modes and a latched interrupt.
module axi_lite_timer_mc #(
   parameter int NUM_CH_p      = 4,
   parameter int CNT_BW_p      = 32,
   parameter int PRESCALE_BW_p = 16,
   parameter int ADDR_BW_p     = 12,
   parameter int DATA_BW_p     = 32
) (
   input  logic                   clk_i,
   input  logic                   rst_i,
   input  logic [ADDR_BW_p-1:0]   awaddr_i,
   input  logic                   awvalid_i,
   output logic                   awready_o,
   input  logic [DATA_BW_p-1:0]   wdata_i,
   input  logic [DATA_BW_p/8-1:0] wstrb_i,
   input  logic                   wvalid_i,
   output logic                   wready_o,
   output logic [1:0]             bresp_o,
   output logic                   bvalid_o,
   input  logic                   bready_i,
   input  logic [ADDR_BW_p-1:0]   araddr_i,
   input  logic                   arvalid_i,
   output logic                   arready_o,
   output logic [DATA_BW_p-1:0]   rdata_o,
   output logic [1:0]             rresp_o,
   output logic                   rvalid_o,
   input  logic                   rready_i,
   output logic [NUM_CH_p-1:0]    irq_o
);

   localparam logic [1:0] OKAY   = 2'b00;
   localparam logic [1:0] SLVERR = 2'b10;
   localparam logic [ADDR_BW_p-3:0] PRE_IDX = (ADDR_BW_p-2)'(32);

   logic                     aw_held;
   logic                     w_held;
   logic                     bvalid;
   logic                     rvalid;
   logic [ADDR_BW_p-1:0]     aw_addr;
   logic [DATA_BW_p-1:0]     w_data;
   logic [DATA_BW_p/8-1:0]   w_strb;
   logic [CNT_BW_p-1:0]      load  [NUM_CH_p];
   logic [CNT_BW_p-1:0]      count [NUM_CH_p];
   logic [2:0]               ctrl  [NUM_CH_p];
   logic [NUM_CH_p-1:0]      pend;
   logic [NUM_CH_p-1:0]      irq;
   logic [NUM_CH_p-1:0]      en;
   logic [NUM_CH_p-1:0]      expire;
   logic [NUM_CH_p-1:0]      wsel;
   logic [PRESCALE_BW_p-1:0] prescale;
   logic [PRESCALE_BW_p-1:0] pcnt;
   logic                     any_en;
   logic                     tick;
   logic                     do_write;
   logic [2:0]               w_ch;
   logic [1:0]               w_reg;
   logic                     w_chan;
   logic                     w_pre;
   logic [2:0]               r_ch;
   logic [1:0]               r_reg;
   logic                     r_chan;
   logic                     r_pre;
   logic [DATA_BW_p-1:0]     rd_data;
   logic                     rd_ok;
   logic                     unused;

   function automatic logic [DATA_BW_p-1:0] merge(
      input logic [DATA_BW_p-1:0]   old,
      input logic [DATA_BW_p-1:0]   data,
      input logic [DATA_BW_p/8-1:0] strb
   );
      logic [DATA_BW_p-1:0] res;
      res = old;
      for (int b = 0; b < DATA_BW_p/8; b++) begin
         if (strb[b]) res[8*b +: 8] = data[8*b +: 8];
      end
      return res;
   endfunction

   assign awready_o = !aw_held;
   assign wready_o  = !w_held;
   assign arready_o = !rvalid;
   assign bvalid_o  = bvalid;
   assign rvalid_o  = rvalid;
   assign irq_o     = irq;
   assign unused    = ^{aw_addr[1:0], araddr_i[1:0]};

   assign do_write = aw_held && w_held && !bvalid;

   assign w_ch   = aw_addr[6:4];
   assign w_reg  = aw_addr[3:2];
   assign w_chan = (aw_addr[ADDR_BW_p-1:7] == '0) && (int'(w_ch) < NUM_CH_p);
   assign w_pre  = aw_addr[ADDR_BW_p-1:2] == PRE_IDX;

   assign r_ch   = araddr_i[6:4];
   assign r_reg  = araddr_i[3:2];
   assign r_chan = (araddr_i[ADDR_BW_p-1:7] == '0) && (int'(r_ch) < NUM_CH_p);
   assign r_pre  = araddr_i[ADDR_BW_p-1:2] == PRE_IDX;

   always_comb begin
      en     = '0;
      expire = '0;
      wsel   = '0;
      for (int n = 0; n < NUM_CH_p; n++) begin
         en[n]   = ctrl[n][0];
         wsel[n] = do_write && w_chan && (w_ch == 3'(n));
      end
      any_en = |en;
      tick   = any_en && (pcnt == prescale);
      for (int n = 0; n < NUM_CH_p; n++) begin
         expire[n] = tick && en[n] && (count[n] == '0);
      end
   end

   always_comb begin
      rd_data = '0;
      rd_ok   = 1'b0;
      if (r_pre) begin
         rd_ok   = 1'b1;
         rd_data = DATA_BW_p'(prescale);
      end
      for (int n = 0; n < NUM_CH_p; n++) begin
         if (r_chan && (r_ch == 3'(n))) begin
            rd_ok = 1'b1;
            case (r_reg)
               2'd0:    rd_data = DATA_BW_p'(ctrl[n]);
               2'd1:    rd_data = DATA_BW_p'(load[n]);
               2'd2:    rd_data = DATA_BW_p'(count[n]);
               default: rd_data = DATA_BW_p'(pend[n]);
            endcase
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         aw_held  <= 1'b0;
         w_held   <= 1'b0;
         bvalid   <= 1'b0;
         rvalid   <= 1'b0;
         bresp_o  <= OKAY;
         rresp_o  <= OKAY;
         rdata_o  <= '0;
         aw_addr  <= '0;
         w_data   <= '0;
         w_strb   <= '0;
         prescale <= '0;
         pcnt     <= '0;
         pend     <= '0;
         irq      <= '0;
         for (int n = 0; n < NUM_CH_p; n++) begin
            load[n]  <= '0;
            count[n] <= '0;
            ctrl[n]  <= '0;
         end
      end else begin
         if (awvalid_i && !aw_held) begin
            aw_held <= 1'b1;
            aw_addr <= awaddr_i;
         end
         if (wvalid_i && !w_held) begin
            w_held <= 1'b1;
            w_data <= wdata_i;
            w_strb <= wstrb_i;
         end
         if (do_write) begin
            bvalid  <= 1'b1;
            bresp_o <= (w_chan || w_pre) ? OKAY : SLVERR;
         end
         if (bvalid && bready_i) begin
            bvalid  <= 1'b0;
            aw_held <= 1'b0;
            w_held  <= 1'b0;
         end

         if (arvalid_i && !rvalid) begin
            rvalid  <= 1'b1;
            rdata_o <= rd_data;
            rresp_o <= rd_ok ? OKAY : SLVERR;
         end else if (rvalid && rready_i) begin
            rvalid <= 1'b0;
         end

         if (do_write && w_pre)
            prescale <= PRESCALE_BW_p'(merge(DATA_BW_p'(prescale), w_data, w_strb));

         if (!any_en || tick) pcnt <= '0;
         else                 pcnt <= pcnt + PRESCALE_BW_p'(1);

         // software writes take priority over the hardware update
         for (int n = 0; n < NUM_CH_p; n++) begin
            if (wsel[n] && (w_reg == 2'd2)) begin
               count[n] <= CNT_BW_p'(merge(DATA_BW_p'(count[n]), w_data, w_strb));
            end else if (tick && en[n]) begin
               if (count[n] != '0) count[n] <= count[n] - CNT_BW_p'(1);
               else if (ctrl[n][1]) count[n] <= load[n];
            end
            if (wsel[n] && (w_reg == 2'd0))
               ctrl[n] <= 3'(merge(DATA_BW_p'(ctrl[n]), w_data, w_strb));
            else if (expire[n] && !ctrl[n][1])
               ctrl[n][0] <= 1'b0;
            if (wsel[n] && (w_reg == 2'd1))
               load[n] <= CNT_BW_p'(merge(DATA_BW_p'(load[n]), w_data, w_strb));
            if (expire[n])
               pend[n] <= 1'b1;
            else if (wsel[n] && (w_reg == 2'd3) && w_strb[0] && w_data[0])
               pend[n] <= 1'b0;
            irq[n] <= pend[n] & ctrl[n][2];
         end
      end
   end

endmodule
